// File: rtl/fp32_mul_pkg.sv
// rtl/fp32_mul_pkg.sv - FP32 field layout, special encodings and flag indices for the multiplier output stage
package fp32_mul_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_W    = 8;
    localparam int EXP_LSB  = 23;
    localparam int MAN_W    = 23;

    localparam logic [EXP_W-1:0] EXP_MAX    = 8'hFF;
    localparam logic [31:0]      QNAN_CANON = 32'h7FC0_0000;

    localparam int FLAG_W    = 4;
    localparam int FLAG_NAN  = 3;
    localparam int FLAG_INF  = 2;
    localparam int FLAG_ZERO = 1;
    localparam int FLAG_DNRM = 0;

    localparam int ENTRY_W = 32 + FLAG_W;

    typedef struct packed {
        logic [FLAG_W-1:0] flags;
        logic [31:0]       data;
    } entry_t;

endpackage

// File: rtl/fp32_mul_out_fifo.sv
// rtl/fp32_mul_out_fifo.sv - DEPTH-entry ring buffer with occupancy level; DEPTH need not be a power of two
module fp32_mul_out_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 36,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [LVL_W-1:0] lvl,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (lvl == LVL_W'(DEPTH));
    assign empty   = (lvl == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   lvl <= lvl + LVL_W'(1);
                2'b01:   lvl <= lvl - LVL_W'(1);
                default: lvl <= lvl;
            endcase
        end
    end

endmodule

// File: rtl/fp32_mul_out_stage.sv
// rtl/fp32_mul_out_stage.sv - classifies fp32 products, flushes denormals / canonicalises NaNs, buffers them for the next stage
module fp32_mul_out_stage
    import fp32_mul_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16,
    parameter int FTZ   = 1
) (
    input  logic                       nvdla_core_clk,
    input  logic                       nvdla_core_rst,
    input  logic [31:0]                chn_o_rsc_z,
    input  logic                       chn_o_rsc_lz,
    output logic                       chn_o_rsc_vz,
    output logic [31:0]                dout_pd,
    output logic [FLAG_W-1:0]          dout_flags,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    input  logic                       cnt_clr,
    output logic [CNT_W-1:0]           nan_cnt,
    output logic [CNT_W-1:0]           inf_cnt,
    output logic [$clog2(DEPTH+1)-1:0] fifo_lvl
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    entry_t           cls;
    entry_t           head;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    assign exp_f = chn_o_rsc_z[EXP_LSB +: EXP_W];
    assign man_f = chn_o_rsc_z[MAN_W-1:0];

    always_comb begin
        cls.data  = chn_o_rsc_z;
        cls.flags = '0;
        if (exp_f == EXP_MAX) begin
            if (man_f != '0) begin
                cls.flags[FLAG_NAN] = 1'b1;
                cls.data            = QNAN_CANON;
            end else begin
                cls.flags[FLAG_INF] = 1'b1;
            end
        end else if (exp_f == '0) begin
            if (man_f != '0) begin
                cls.flags[FLAG_DNRM] = 1'b1;
                // A flushed denormal becomes a signed zero and is flagged as such.
                if (FTZ != 0) begin
                    cls.flags[FLAG_ZERO] = 1'b1;
                    cls.data             = {chn_o_rsc_z[SIGN_BIT], 31'b0};
                end
            end else begin
                cls.flags[FLAG_ZERO] = 1'b1;
            end
        end
    end

    // Ready comes from registered occupancy only, so full + pop still refuses a push.
    assign chn_o_rsc_vz = ~nvdla_core_rst & ~full;
    assign push         = chn_o_rsc_lz & chn_o_rsc_vz;
    assign dout_valid   = ~empty;
    assign pop          = dout_valid & dout_ready;

    fp32_mul_out_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .LVL_W ($clog2(DEPTH + 1))
    ) u_fifo (
        .clk   (nvdla_core_clk),
        .rst   (nvdla_core_rst),
        .push  (push),
        .pop   (pop),
        .wdata (cls),
        .rdata (head),
        .lvl   (fifo_lvl),
        .full  (full),
        .empty (empty)
    );

    assign dout_pd    = head.data;
    assign dout_flags = head.flags;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst || cnt_clr) begin
            nan_cnt <= '0;
            inf_cnt <= '0;
        end else if (push) begin
            if (cls.flags[FLAG_NAN] && (nan_cnt != '1)) begin
                nan_cnt <= nan_cnt + CNT_W'(1);
            end
            if (cls.flags[FLAG_INF] && (inf_cnt != '1)) begin
                inf_cnt <= inf_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fp32_mul_out_stage.sv
// tb/tb_fp32_mul_out_stage.sv - scoreboard bench for fp32_mul_out_stage, FTZ=1 and FTZ=0 instances side by side
module tb_fp32_mul_out_stage;

    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    typedef struct {
        logic [31:0] d1;
        logic [3:0]  f1;
        logic [31:0] d0;
        logic [3:0]  f0;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      zin = '0;
    logic             lz  = 1'b0;
    logic             rdy = 1'b0;
    logic             clr = 1'b0;

    logic             a_vz, a_val, b_vz, b_val;
    logic [31:0]      a_pd, b_pd;
    logic [3:0]       a_fl, b_fl;
    logic [CNT_W-1:0] a_nan, a_inf, b_nan, b_inf;
    logic [LVL_W-1:0] a_lvl, b_lvl;

    exp_t q[$];
    int   m_nan = 0;
    int   m_inf = 0;
    bit   post_rst = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fp32_mul_out_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W), .FTZ(1)) dut_ftz (
        .nvdla_core_clk (clk),   .nvdla_core_rst (rst),
        .chn_o_rsc_z    (zin),   .chn_o_rsc_lz   (lz),   .chn_o_rsc_vz (a_vz),
        .dout_pd        (a_pd),  .dout_flags     (a_fl), .dout_valid   (a_val),
        .dout_ready     (rdy),   .cnt_clr        (clr),
        .nan_cnt        (a_nan), .inf_cnt        (a_inf), .fifo_lvl    (a_lvl)
    );

    fp32_mul_out_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W), .FTZ(0)) dut_keep (
        .nvdla_core_clk (clk),   .nvdla_core_rst (rst),
        .chn_o_rsc_z    (zin),   .chn_o_rsc_lz   (lz),   .chn_o_rsc_vz (b_vz),
        .dout_pd        (b_pd),  .dout_flags     (b_fl), .dout_valid   (b_val),
        .dout_ready     (rdy),   .cnt_clr        (clr),
        .nan_cnt        (b_nan), .inf_cnt        (b_inf), .fifo_lvl    (b_lvl)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: returns {flags, data} for a product, from the IEEE-754 category rules.
    function automatic logic [35:0] classify(input logic [31:0] z, input bit ftz);
        int unsigned e, m;
        e = (z >> 23) & 32'hFF;
        m = z & 32'h7F_FFFF;
        if (e == 255 && m != 0) return {4'b1000, 32'h7FC0_0000};
        if (e == 255)           return {4'b0100, z};
        if (e == 0 && m != 0)   return ftz ? {4'b0011, z & 32'h8000_0000} : {4'b0001, z};
        if (e == 0)             return {4'b0010, z};
        return {4'b0000, z};
    endfunction

    function automatic logic [31:0] rand_val();
        logic [31:0] s, e, m;
        s = $urandom_range(0, 1);
        m = $urandom_range(1, 32'h7F_FFFF);
        case ($urandom_range(0, 5))
            0:       e = $urandom_range(1, 254);
            1:       e = 255;
            2:       begin e = 255; m = 0; end
            3:       e = 0;
            4:       begin e = 0; m = 0; end
            default: return $urandom;
        endcase
        return (s << 31) | (e << 23) | m;
    endfunction

    task automatic step(input logic r, input logic l, input logic [31:0] z,
                        input logic rd, input logic c);
        logic [35:0] c1, c0;
        exp_t        ex;
        bit          acc;
        @(negedge clk);
        rst = r; lz = l; zin = z; rdy = rd; clr = c;
        #1;
        if (r) begin
            chk("vz_in_reset_ftz", {31'b0, a_vz}, 32'd0);
            chk("vz_in_reset_keep", {31'b0, b_vz}, 32'd0);
            q.delete();
            m_nan = 0;
            m_inf = 0;
            post_rst = 1;
        end else begin
            chk("lvl_ftz",   32'(a_lvl), 32'(q.size()));
            chk("lvl_keep",  32'(b_lvl), 32'(q.size()));
            chk("valid_ftz", {31'b0, a_val}, {31'b0, q.size() != 0});
            chk("valid_keep",{31'b0, b_val}, {31'b0, q.size() != 0});
            chk("vz_ftz",    {31'b0, a_vz}, {31'b0, q.size() != DEPTH});
            chk("vz_keep",   {31'b0, b_vz}, {31'b0, q.size() != DEPTH});
            chk("nan_cnt",   32'(a_nan), 32'(m_nan));
            chk("inf_cnt",   32'(a_inf), 32'(m_inf));
            chk("nan_cnt_keep", 32'(b_nan), 32'(m_nan));
            chk("inf_cnt_keep", 32'(b_inf), 32'(m_inf));
            if (post_rst) begin
                chk("pd_after_reset",    a_pd, 32'd0);
                chk("flags_after_reset", 32'(a_fl), 32'd0);
                post_rst = 0;
            end
            acc = l && (q.size() < DEPTH);
            c1 = classify(z, 1);
            c0 = classify(z, 0);
            if (acc) begin
                ex.d1 = c1[31:0]; ex.f1 = c1[35:32];
                ex.d0 = c0[31:0]; ex.f0 = c0[35:32];
                q.push_back(ex);
            end
            if (c) begin
                m_nan = 0;
                m_inf = 0;
            end else if (acc) begin
                if (c1[35] && m_nan < CMAX) m_nan++;
                if (c1[34] && m_inf < CMAX) m_inf++;
            end
        end
    endtask

    // Monitor: whenever a head entry is presented, it must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && (a_val || b_val)) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", {31'b0, a_val | b_val}, 32'd0);
                end else begin
                    chk("head_pd_ftz",    a_pd,       q[0].d1);
                    chk("head_flags_ftz", 32'(a_fl),  32'(q[0].f1));
                    chk("head_pd_keep",   b_pd,       q[0].d0);
                    chk("head_flags_keep",32'(b_fl),  32'(q[0].f0));
                    if (rdy) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // single push into empty FIFO, held on the output
        step(0, 1, 32'h3F80_0000, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        // overfill with ready low, then drain in order
        step(0, 1, 32'h4000_0000, 0, 0);
        step(0, 1, 32'h4040_0000, 0, 0);
        step(0, 1, 32'h4080_0000, 0, 0);
        step(0, 1, 32'h40A0_0000, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        // special encodings
        step(0, 1, 32'hFFC1_2345, 1, 0);
        step(0, 1, 32'h7F80_0000, 1, 0);
        step(0, 1, 32'h8000_0001, 1, 0);
        step(0, 1, 32'h0000_0000, 1, 0);
        step(0, 1, 32'h8000_0000, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        // saturate counters, then clear against a same-cycle NaN push
        for (int i = 0; i < 18; i++) step(0, 1, 32'h7FA0_0001, 1, 0);
        for (int i = 0; i < 17; i++) step(0, 1, 32'hFF80_0000, 1, 0);
        step(0, 1, 32'h7FFF_FFFF, 1, 1);
        step(0, 0, 0, 1, 0);
        // reset with a full FIFO
        step(0, 1, 32'h3F80_0000, 0, 0);
        step(0, 1, 32'h0000_0001, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), rand_val(),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0));
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
